// File: rtl/lanes_serializer.sv
// Two-lane parallel-to-serial stage: words enter a single-entry hold register via valid/ready, then leave one bit per clock per lane.
// First bit appears the cycle after the load edge. tx_ready is low while the hold register is full; the line itself never stalls.
module lanes_serializer (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [1:0]   gen_speed,
    input  logic [131:0] Lane_0_tx_in,
    input  logic [131:0] Lane_1_tx_in,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic         Lane_0_tx_out,
    output logic         Lane_1_tx_out,
    output logic         symbol_start,
    output logic         underflow,
    output logic         tx_active
);

    typedef enum logic [1:0] {ST_OFF, ST_PRIME, ST_RUN} state_t;

    state_t       state_q, state_d;
    logic [1:0]   speed_q, speed_d;
    logic         hold_full_q, hold_full_d;
    logic [131:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic [131:0] sym0_q, sym0_d, sym1_q, sym1_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic         out0_q, out0_d, out1_q, out1_d;
    logic         underflow_q, underflow_d;
    logic [7:0]   last_cnt;
    logic [7:0]   idx;
    logic         accept;
    logic         load;

    assign tx_ready      = (state_q != ST_OFF) && !hold_full_q;
    assign accept        = tx_valid && tx_ready;
    assign Lane_0_tx_out = out0_q;
    assign Lane_1_tx_out = out1_q;
    assign underflow     = underflow_q;
    assign tx_active     = (state_q == ST_RUN);
    assign symbol_start  = (state_q == ST_RUN) && (bit_cnt_q == 8'd0);

    always_comb begin
        case (speed_q)
            2'b01:   last_cnt = 8'd131;
            2'b10:   last_cnt = 8'd65;
            default: last_cnt = 8'd7;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        hold_full_d = hold_full_q;
        hold0_d     = hold0_q;
        hold1_d     = hold1_q;
        sym0_d      = sym0_q;
        sym1_d      = sym1_q;
        bit_cnt_d   = bit_cnt_q;
        underflow_d = 1'b0;
        load        = 1'b0;

        if (!enable) begin
            state_d     = ST_OFF;
            hold_full_d = 1'b0;
            hold0_d     = '0;
            hold1_d     = '0;
            sym0_d      = '0;
            sym1_d      = '0;
            bit_cnt_d   = 8'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    speed_d = gen_speed;
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (bit_cnt_q == last_cnt) begin
                        bit_cnt_d = 8'd0;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            // Nothing queued: keep the line running with an idle symbol.
                            sym0_d      = '0;
                            sym1_d      = '0;
                            underflow_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            endcase

            if (load) begin
                sym0_d      = hold0_q;
                sym1_d      = hold1_q;
                hold_full_d = 1'b0;
                bit_cnt_d   = 8'd0;
            end
            if (accept) begin
                hold0_d     = Lane_0_tx_in;
                hold1_d     = Lane_1_tx_in;
                hold_full_d = 1'b1;
            end
        end

        // Output bit is picked from next-state values so the registered line bit lines up with bit_cnt.
        idx    = (last_cnt == 8'd7) ? (8'd7 - bit_cnt_d) : bit_cnt_d;
        out0_d = (state_d == ST_RUN) ? sym0_d[idx] : 1'b0;
        out1_d = (state_d == ST_RUN) ? sym1_d[idx] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            speed_q     <= 2'b00;
            hold_full_q <= 1'b0;
            hold0_q     <= '0;
            hold1_q     <= '0;
            sym0_q      <= '0;
            sym1_q      <= '0;
            bit_cnt_q   <= 8'd0;
            out0_q      <= 1'b0;
            out1_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            hold_full_q <= hold_full_d;
            hold0_q     <= hold0_d;
            hold1_q     <= hold1_d;
            sym0_q      <= sym0_d;
            sym1_q      <= sym1_d;
            bit_cnt_q   <= bit_cnt_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_lanes_serializer.sv
// Bench for lanes_serializer: constant-table and hand-written corner sequences plus randomized traffic against a queue-based line model.
module tb_lanes_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   gen_speed;
    logic [131:0] Lane_0_tx_in;
    logic [131:0] Lane_1_tx_in;
    logic         tx_valid;
    logic         tx_ready;
    logic         Lane_0_tx_out;
    logic         Lane_1_tx_out;
    logic         symbol_start;
    logic         underflow;
    logic         tx_active;

    int total  = 0;
    int passed = 0;

    lanes_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .gen_speed    (gen_speed),
        .Lane_0_tx_in (Lane_0_tx_in),
        .Lane_1_tx_in (Lane_1_tx_in),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .Lane_0_tx_out(Lane_0_tx_out),
        .Lane_1_tx_out(Lane_1_tx_out),
        .symbol_start (symbol_start),
        .underflow    (underflow),
        .tx_active    (tx_active)
    );

    always #5 clk = ~clk;

    // Model: line contents are a queue of bits still to be sent for the current symbol.
    int           m_mode;
    int           m_n;
    bit           m_hfull;
    bit           m_uf;
    logic [131:0] m_h0, m_h1;
    bit           q0[$];
    bit           q1[$];

    function automatic int sym_len(input logic [1:0] g);
        if (g == 2'b01) return 132;
        if (g == 2'b10) return 66;
        return 8;
    endfunction

    function automatic bit m_ready();
        return (m_mode != 0) && !m_hfull;
    endfunction

    function automatic void push_symbol(input logic [131:0] w0, input logic [131:0] w1);
        for (int k = 0; k < m_n; k++) begin
            q0.push_back((m_n == 8) ? w0[7-k] : w0[k]);
            q1.push_back((m_n == 8) ? w1[7-k] : w1[k]);
        end
    endfunction

    function automatic void model_reset();
        m_mode  = 0;
        m_hfull = 1'b0;
        m_uf    = 1'b0;
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_edge();
        bit acc;
        acc  = tx_valid && m_ready();
        m_uf = 1'b0;
        if (!enable) begin
            model_reset();
            return;
        end
        if (m_mode == 0) begin
            m_n    = sym_len(gen_speed);
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_hfull) begin
                push_symbol(m_h0, m_h1);
                m_hfull = 1'b0;
                m_mode  = 2;
            end
        end else begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            if (q0.size() == 0) begin
                if (m_hfull) begin
                    push_symbol(m_h0, m_h1);
                    m_hfull = 1'b0;
                end else begin
                    push_symbol('0, '0);
                    m_uf = 1'b1;
                end
            end
        end
        if (acc) begin
            m_h0    = Lane_0_tx_in;
            m_h1    = Lane_1_tx_in;
            m_hfull = 1'b1;
        end
    endfunction

    function automatic logic [5:0] m_exp();
        if (m_mode == 2)
            return {q0[0], q1[0], q0.size() == m_n, m_uf, 1'b1, !m_hfull};
        return {5'b0, m_ready()};
    endfunction

    function automatic logic [5:0] dut_vec();
        return {Lane_0_tx_out, Lane_1_tx_out, symbol_start, underflow, tx_active, tx_ready};
    endfunction

    function automatic logic [131:0] rand132();
        logic [131:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w = {w[99:0], $urandom()};
        return w;
    endfunction

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        chk("cycle", dut_vec(), m_exp());
    endtask

    task automatic start(input logic [1:0] g);
        tx_valid = 1'b0;
        enable   = 1'b0;
        rst      = 1'b1;
        tick();
        rst       = 1'b0;
        enable    = 1'b1;
        gen_speed = g;
        tick();
    endtask

    task automatic send(input logic [131:0] w0, input logic [131:0] w1);
        bit done;
        done         = 1'b0;
        Lane_0_tx_in = w0;
        Lane_1_tx_in = w1;
        tx_valid     = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            done = tx_ready;
            tick();
        end
        if (!done) chk("send_timeout", 0, 1);
        tx_valid = 1'b0;
    endtask

    task automatic collect(input int n, output logic [131:0] g0, output logic [131:0] g1, output int starts);
        int w;
        w      = 0;
        g0     = '0;
        g1     = '0;
        starts = 0;
        while (!symbol_start && w < 300) begin
            tick();
            w++;
        end
        if (!symbol_start) chk("start_timeout", 0, 1);
        for (int k = 0; k < n; k++) begin
            g0[k] = Lane_0_tx_out;
            g1[k] = Lane_1_tx_out;
            starts += int'(symbol_start);
            tick();
        end
    endtask

    task automatic run_random(input int cycles, input int p);
        bit acc;
        for (int c = 0; c < cycles; c++) begin
            if (!tx_valid && $urandom_range(1, 100) <= p) begin
                tx_valid     = 1'b1;
                Lane_0_tx_in = rand132();
                Lane_1_tx_in = rand132();
            end
            gen_speed = 2'($urandom_range(0, 3));
            if (!enable) enable = 1'b1;
            else if ($urandom_range(0, 299) == 0) enable = 1'b0;
            acc = tx_valid && tx_ready;
            tick();
            if (acc) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0] gen;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec8_t;

    initial begin
        vec8_t        tbl[4];
        logic [131:0] g0, g1, w, ws[3];
        int           s, ufc, stc;
        bit           acc;
        int           widx;

        // Expected fields hold the emitted sequence with the first bit in position 0.
        tbl[0] = '{gen: 2'b00, b0: 8'hA5, b1: 8'h3C, e0: 8'hA5, e1: 8'h3C};
        tbl[1] = '{gen: 2'b11, b0: 8'h01, b1: 8'hF0, e0: 8'h80, e1: 8'h0F};
        tbl[2] = '{gen: 2'b00, b0: 8'h12, b1: 8'hC3, e0: 8'h48, e1: 8'hC3};
        tbl[3] = '{gen: 2'b11, b0: 8'h80, b1: 8'h7E, e0: 8'h01, e1: 8'h7E};

        rst          = 1'b1;
        enable       = 1'b0;
        gen_speed    = 2'b00;
        tx_valid     = 1'b0;
        Lane_0_tx_in = '0;
        Lane_1_tx_in = '0;
        model_reset();
        #1;
        chk("reset_state", dut_vec(), 6'b0);
        tick();
        rst = 1'b0;

        // Test 1: 132-bit symbol, LSB first, then an idle symbol with underflow.
        start(2'b01);
        send(132'h1, {1'b1, 131'h0});
        tick();
        chk("t1_first_bit", {symbol_start, Lane_0_tx_out, Lane_1_tx_out, tx_ready}, 4'b1101);
        collect(132, g0, g1, s);
        chk("t1_lane0", g0, 132'h1);
        chk("t1_lane1", g1, {1'b1, 131'h0});
        chk("t1_starts", s, 1);
        chk("t1_idle", {symbol_start, underflow, Lane_0_tx_out, Lane_1_tx_out}, 4'b1100);

        // Test 2: 8-bit symbols, MSB first, upper bits ignored.
        for (int i = 0; i < 4; i++) begin
            start(tbl[i].gen);
            send({{124{1'b1}}, tbl[i].b0}, {{124{1'b1}}, tbl[i].b1});
            collect(8, g0, g1, s);
            chk("t2_lane0", g0, {124'b0, tbl[i].e0});
            chk("t2_lane1", g1, {124'b0, tbl[i].e1});
            chk("t2_next_start", {symbol_start, underflow}, 2'b11);
        end

        // Test 3: back-to-back 66-bit symbols with valid held high.
        start(2'b10);
        for (int i = 0; i < 3; i++) ws[i] = rand132();
        widx         = 0;
        Lane_0_tx_in = ws[0];
        Lane_1_tx_in = ~ws[0];
        tx_valid     = 1'b1;
        ufc          = 0;
        stc          = 0;
        g0           = '0;
        for (int t = 1; t <= 200; t++) begin
            acc = tx_valid && tx_ready;
            tick();
            if (t < 200) begin
                ufc += int'(underflow);
                stc += int'(symbol_start);
            end
            if (t >= 68 && t < 134) g0[t-68] = Lane_0_tx_out;
            if (acc) begin
                widx++;
                if (widx < 3) begin
                    Lane_0_tx_in = ws[widx];
                    Lane_1_tx_in = ~ws[widx];
                end else begin
                    tx_valid = 1'b0;
                end
            end
        end
        chk("t3_no_underflow", ufc, 0);
        chk("t3_starts", stc, 3);
        chk("t3_w1_bits", g0, {66'b0, ws[1][65:0]});
        chk("t3_final_underflow", underflow, 1'b1);

        // Test 4: single word, idle symbol, then a late word at the next boundary.
        start(2'b10);
        w = rand132();
        send(w, ~w);
        collect(66, g0, g1, s);
        chk("t4_lane0", g0, {66'b0, w[65:0]});
        chk("t4_uf_start", {underflow, symbol_start, Lane_0_tx_out, Lane_1_tx_out}, 4'b1100);
        tick();
        chk("t4_uf_pulse", underflow, 1'b0);
        w = rand132();
        send(w, ~w);
        collect(66, g0, g1, s);
        chk("t4_late_lane0", g0, {66'b0, w[65:0]});
        chk("t4_late_lane1", g1, {66'b0, ~w[65:0]});

        // Test 5: enable drop mid-symbol, gen_speed change ignored until re-enable.
        start(2'b01);
        w = rand132();
        send(w, ~w);
        tick();
        for (int i = 0; i < 40; i++) tick();
        enable = 1'b0;
        tick();
        chk("t5_off", dut_vec(), 6'b0);
        enable    = 1'b1;
        gen_speed = 2'b01;
        tick();
        gen_speed = 2'b00;
        w = rand132();
        send(w, ~w);
        collect(132, g0, g1, s);
        chk("t5_still132", g0, w);
        chk("t5_one_start", s, 1);
        chk("t5_period", symbol_start, 1'b1);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        send({{124{1'b0}}, 8'h01}, {{124{1'b1}}, 8'hF0});
        collect(8, g0, g1, s);
        chk("t5_now8", g0, {124'b0, 8'h80});
        chk("t5_period8", symbol_start, 1'b1);

        // Test 6: asynchronous reset mid-symbol.
        start(2'b01);
        w = rand132() | 132'h1;
        send(w, w);
        tick();
        for (int i = 0; i < 20; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async", dut_vec(), 6'b0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_prime", {tx_ready, tx_active}, 2'b10);

        // Randomized traffic with enable drops and gen_speed noise.
        for (int r = 0; r < 6; r++) begin
            start(2'($urandom_range(0, 3)));
            run_random(1200, $urandom_range(20, 100));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
